// File: rtl/conv2d_engine_if.sv
// Pixel stream, weight write port and tagged output stream for conv2d_engine.
interface conv2d_engine_if #(
  parameter int IMG_SIZE = 28,
  parameter int K        = 3,
  parameter int NUM_FILT = 16,
  parameter int STRIDE   = 2,
  parameter int DATA_W   = 16
);
  localparam int OUT_SIZE = (IMG_SIZE - K) / STRIDE + 1;
  localparam int WA_W     = (NUM_FILT * K * K > 1) ? $clog2(NUM_FILT * K * K) : 1;
  localparam int F_W      = (NUM_FILT > 1) ? $clog2(NUM_FILT) : 1;
  localparam int P_W      = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;

  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data;
  logic                     w_we;
  logic        [WA_W-1:0]   w_addr;
  logic signed [DATA_W-1:0] w_data;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_data;
  logic        [F_W-1:0]    out_filt;
  logic        [P_W-1:0]    out_row;
  logic        [P_W-1:0]    out_col;
  logic                     busy;
  logic                     frame_done;

  modport master (
    output in_valid, in_data, w_we, w_addr, w_data, out_ready,
    input  in_ready, out_valid, out_data, out_filt, out_row, out_col, busy, frame_done
  );

  modport slave (
    input  in_valid, in_data, w_we, w_addr, w_data, out_ready,
    output in_ready, out_valid, out_data, out_filt, out_row, out_col, busy, frame_done
  );
endinterface

// File: rtl/conv2d_engine.sv
// Frame-buffered 2-D convolution, one MAC per cycle, saturated tagged output stream.
// Optional CONV_RELU_EN clamps negative results to zero.
// state   | meaning
// IDLE    | waiting for pixel 0 of a frame
// LOAD    | storing the remaining pixels of the frame
// COMPUTE | accumulating the K*K taps of one output
// EMIT    | presenting one output until it is accepted
module conv2d_engine #(
  parameter int IMG_SIZE = 28,
  parameter int K        = 3,
  parameter int NUM_FILT = 16,
  parameter int STRIDE   = 2,
  parameter int DATA_W   = 16,
  parameter int FRAC_W   = 8
) (
  input logic            clk,
  input logic            rstb,
  conv2d_engine_if.slave bus
);
  localparam int OUT_SIZE = (IMG_SIZE - K) / STRIDE + 1;
  localparam int NPIX     = IMG_SIZE * IMG_SIZE;
  localparam int NTAP     = K * K;
  localparam int NW       = NUM_FILT * NTAP;
  localparam int ACC_W    = 2 * DATA_W + $clog2(NTAP);
  localparam int PIX_W    = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int WA_W     = (NW > 1) ? $clog2(NW) : 1;
  localparam int K_W      = (K > 1) ? $clog2(K) : 1;
  localparam int F_W      = (NUM_FILT > 1) ? $clog2(NUM_FILT) : 1;
  localparam int P_W      = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMPUTE, S_EMIT} state_t;

  state_t                     r_state, w_state_nxt;
  logic        [PIX_W-1:0]    r_pix_cnt;
  logic        [K_W-1:0]      r_kx, r_ky;
  logic        [F_W-1:0]      r_filt;
  logic        [P_W-1:0]      r_row, r_col;
  logic signed [ACC_W-1:0]    r_acc;
  logic                       r_frame_done;
  logic signed [DATA_W-1:0]   r_frame  [NPIX];
  logic signed [DATA_W-1:0]   r_weight [NW];

  logic                       w_in_hs, w_last_pix, w_last_tap, w_last_out;
  logic        [PIX_W-1:0]    w_frame_addr;
  logic        [WA_W-1:0]     w_wgt_addr;
  logic signed [DATA_W-1:0]   w_pix, w_wgt, w_sat;
  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [ACC_W-1:0]    w_prod_x, w_shift;

  assign w_in_hs    = bus.in_valid && bus.in_ready;
  assign w_last_pix = (r_pix_cnt == PIX_W'(NPIX - 1));
  assign w_last_tap = (r_kx == K_W'(K - 1)) && (r_ky == K_W'(K - 1));
  assign w_last_out = (r_filt == F_W'(NUM_FILT - 1)) && (r_col == P_W'(OUT_SIZE - 1)) &&
                      (r_row == P_W'(OUT_SIZE - 1));

  always_comb begin
    int v_pix;
    int v_wgt;
    v_pix = (int'(r_row) * STRIDE + int'(r_ky)) * IMG_SIZE + int'(r_col) * STRIDE + int'(r_kx);
    v_wgt = int'(r_filt) * NTAP + int'(r_ky) * K + int'(r_kx);
    w_frame_addr = PIX_W'(v_pix);
    w_wgt_addr   = WA_W'(v_wgt);
  end

  assign w_pix    = r_frame[w_frame_addr];
  assign w_wgt    = r_weight[w_wgt_addr];
  assign w_prod   = (2*DATA_W)'(w_pix) * (2*DATA_W)'(w_wgt);
  assign w_prod_x = ACC_W'(w_prod);
  assign w_shift  = r_acc >>> FRAC_W;

  always_comb begin
    if (w_shift > SAT_MAX)      w_sat = {1'b0, {(DATA_W-1){1'b1}}};
    else if (w_shift < SAT_MIN) w_sat = {1'b1, {(DATA_W-1){1'b0}}};
    else                        w_sat = w_shift[DATA_W-1:0];
  end

`ifdef CONV_RELU_EN
  assign bus.out_data = w_sat[DATA_W-1] ? '0 : w_sat;
`else
  assign bus.out_data = w_sat;
`endif
  assign bus.out_filt   = r_filt;
  assign bus.out_row    = r_row;
  assign bus.out_col    = r_col;
  assign bus.frame_done = r_frame_done;

  always_ff @(posedge clk) begin
    if (!rstb) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:    if (w_in_hs) w_state_nxt = S_LOAD;
      S_LOAD:    if (w_in_hs && w_last_pix) w_state_nxt = S_COMPUTE;
      S_COMPUTE: if (w_last_tap) w_state_nxt = S_EMIT;
      S_EMIT:    if (bus.out_ready) w_state_nxt = w_last_out ? S_IDLE : S_COMPUTE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (r_state == S_IDLE) || (r_state == S_LOAD);
    bus.out_valid = (r_state == S_EMIT);
    bus.busy      = (r_state == S_COMPUTE) || (r_state == S_EMIT);
  end

  // Position/filter walk: filter innermost, then column, then row.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      r_pix_cnt    <= '0;
      r_kx         <= '0;
      r_ky         <= '0;
      r_filt       <= '0;
      r_row        <= '0;
      r_col        <= '0;
      r_acc        <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      unique case (r_state)
        S_IDLE: if (w_in_hs) r_pix_cnt <= PIX_W'(1);
        S_LOAD: if (w_in_hs) begin
          if (w_last_pix) begin
            r_pix_cnt <= '0;
            r_kx      <= '0;
            r_ky      <= '0;
            r_filt    <= '0;
            r_row     <= '0;
            r_col     <= '0;
            r_acc     <= '0;
          end else begin
            r_pix_cnt <= r_pix_cnt + 1'b1;
          end
        end
        S_COMPUTE: begin
          r_acc <= r_acc + w_prod_x;
          if (r_kx == K_W'(K - 1)) begin
            r_kx <= '0;
            r_ky <= (r_ky == K_W'(K - 1)) ? '0 : r_ky + 1'b1;
          end else begin
            r_kx <= r_kx + 1'b1;
          end
        end
        S_EMIT: if (bus.out_ready) begin
          r_acc <= '0;
          if (r_filt == F_W'(NUM_FILT - 1)) begin
            r_filt <= '0;
            if (r_col == P_W'(OUT_SIZE - 1)) begin
              r_col <= '0;
              if (r_row == P_W'(OUT_SIZE - 1)) begin
                r_row        <= '0;
                r_frame_done <= 1'b1;
              end else begin
                r_row <= r_row + 1'b1;
              end
            end else begin
              r_col <= r_col + 1'b1;
            end
          end else begin
            r_filt <= r_filt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Storage is deliberately not reset: weights must survive a reset.
  always_ff @(posedge clk) begin
    if (w_in_hs) r_frame[r_pix_cnt] <= bus.in_data;
    if (bus.w_we && !bus.busy) r_weight[bus.w_addr] <= bus.w_data;
  end
endmodule

// File: tb/tb_conv2d_engine.sv
// Scoreboard bench for conv2d_engine on a 5x5 frame, 3x3 kernel, 2 filters, stride 2.
module tb_conv2d_engine;
  localparam int IMG = 5;
  localparam int KK  = 3;
  localparam int NF  = 2;
  localparam int STR = 2;
  localparam int DW  = 16;
  localparam int FW  = 8;

  logic clk  = 1'b0;
  logic rstb = 1'b0;
  always #5 clk = ~clk;

  conv2d_engine_if #(.IMG_SIZE(IMG), .K(KK), .NUM_FILT(NF), .STRIDE(STR), .DATA_W(DW)) bus ();

  conv2d_engine #(.IMG_SIZE(IMG), .K(KK), .NUM_FILT(NF), .STRIDE(STR), .DATA_W(DW), .FRAC_W(FW))
    dut (.clk(clk), .rstb(rstb), .bus(bus));

  typedef struct {
    logic [15:0] data;
    int          filt;
    int          row;
    int          col;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   n_out = 0;
  bit   stall_mode = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares the presented output against the queue head on every valid cycle,
  // so a stalled output must stay equal to its expected value until it is taken.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rstb && bus.out_valid) begin
        if (q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_output: got r%0d c%0d f%0d data %0h, expected none",
                   bus.out_row, bus.out_col, bus.out_filt, bus.out_data);
          if (bus.out_ready) n_out++;
        end else begin
          e = q[0];
          check("out_data", {16'h0, bus.out_data}, {16'h0, e.data});
          check("out_filt", 32'(bus.out_filt), e.filt);
          check("out_row", 32'(bus.out_row), e.row);
          check("out_col", 32'(bus.out_col), e.col);
          if (bus.out_ready) begin
            void'(q.pop_front());
            n_out++;
          end
        end
      end
    end
  end

  // Consumer: always ready, or holds off 7 cycles on every output when stalling.
  initial begin
    int cnt;
    cnt = 0;
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (!stall_mode) begin
        bus.out_ready = 1'b1;
      end else if (bus.out_valid) begin
        if (cnt >= 7) bus.out_ready = 1'b1;
        else begin
          bus.out_ready = 1'b0;
          cnt++;
        end
      end else begin
        bus.out_ready = 1'b0;
        cnt = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic write_w(input int a, input logic [15:0] d);
    bus.w_we   = 1'b1;
    bus.w_addr = 5'(a);
    bus.w_data = d;
    tick();
    bus.w_we   = 1'b0;
  endtask

  task automatic set_weights_all(input logic [15:0] d);
    for (int a = 0; a < NF * KK * KK; a++) write_w(a, d);
  endtask

  task automatic push_all(input logic [15:0] d);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++)
        for (int f = 0; f < NF; f++) q.push_back('{d, f, r, c});
  endtask

  // mode 1: pixel i = i*256, otherwise every pixel = val
  task automatic load_frame(input int mode, input logic [15:0] val, input bit measure);
    int n;
    for (int i = 0; i < IMG * IMG; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = (mode == 1) ? 16'(i * 256) : val;
      tick();
    end
    bus.in_valid = 1'b0;
    check("busy_compute", 32'(bus.busy), 1);
    check("in_ready_compute", 32'(bus.in_ready), 0);
    if (measure) begin
      n = 1;  // the accepting cycle of the last pixel
      while (!bus.out_valid && n < 100) begin
        tick();
        n++;
      end
      check("latency", n, KK * KK + 1);
    end
  endtask

  task automatic wait_done(input int base);
    int n;
    n = 0;
    while (!bus.frame_done && n < 3000) begin
      tick();
      n++;
    end
    check("frame_done_seen", 32'(bus.frame_done), 1);
    check("in_ready_at_done", 32'(bus.in_ready), 1);
    check("outputs_count", n_out - base, 8);
    check("queue_empty", q.size(), 0);
    tick();
    check("frame_done_pulse", 32'(bus.frame_done), 0);
  endtask

  initial begin
    int base;
    int n;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.w_we     = 1'b0;
    bus.w_addr   = '0;
    bus.w_data   = '0;

    repeat (3) tick();
    check("rst_in_ready", 32'(bus.in_ready), 1);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_frame_done", 32'(bus.frame_done), 0);
    check("rst_out_data", {16'h0, bus.out_data}, 0);
    check("rst_tags", {bus.out_filt, bus.out_row, bus.out_col}, 0);
    rstb = 1'b1;
    tick();

    // Unity frame
    set_weights_all(16'd256);
    push_all(16'd2304);
    base = n_out;
    load_frame(0, 16'd256, 1'b1);
    wait_done(base);

    // Position tags: centre tap of filter 0 only
    for (int a = 0; a < NF * KK * KK; a++) write_w(a, (a == 4) ? 16'd256 : 16'd0);
    q.push_back('{16'd1536, 0, 0, 0}); q.push_back('{16'd0, 1, 0, 0});
    q.push_back('{16'd2048, 0, 0, 1}); q.push_back('{16'd0, 1, 0, 1});
    q.push_back('{16'd4096, 0, 1, 0}); q.push_back('{16'd0, 1, 1, 0});
    q.push_back('{16'd4608, 0, 1, 1}); q.push_back('{16'd0, 1, 1, 1});
    base = n_out;
    load_frame(1, 16'd0, 1'b0);
    wait_done(base);

    // Saturation, both directions
    set_weights_all(16'h7FFF);
    push_all(16'h7FFF);
    base = n_out;
    load_frame(0, 16'h7FFF, 1'b0);
    wait_done(base);

    set_weights_all(16'h8001);
`ifdef CONV_RELU_EN
    push_all(16'h0000);
`else
    push_all(16'h8000);
`endif
    base = n_out;
    load_frame(0, 16'h7FFF, 1'b0);
    wait_done(base);

    // Negative result
    set_weights_all(16'hFF00);
`ifdef CONV_RELU_EN
    push_all(16'h0000);
`else
    push_all(16'hF700);
`endif
    base = n_out;
    load_frame(0, 16'd256, 1'b0);
    wait_done(base);

    // Backpressure with ignored weight writes and ignored pixels while busy
    set_weights_all(16'd256);
    stall_mode = 1'b1;
    push_all(16'd2304);
    base = n_out;
    load_frame(0, 16'd256, 1'b0);
    n = 0;
    while (bus.busy && n < 1000) begin
      bus.w_we     = 1'b1;
      bus.w_addr   = 5'(n % (NF * KK * KK));
      bus.w_data   = 16'h1234;
      bus.in_valid = (n < 6);
      bus.in_data  = 16'h4000;
      tick();
      n++;
    end
    bus.w_we     = 1'b0;
    bus.in_valid = 1'b0;
    wait_done(base);
    stall_mode = 1'b0;
    tick();

    // Reset during COMPUTE of output 3, then a clean unity frame on the kept weights
    push_all(16'd2304);
    base = n_out;
    load_frame(0, 16'd256, 1'b0);
    n = 0;
    while (n_out - base < 3 && n < 500) begin
      tick();
      n++;
    end
    check("reach_output3", n_out - base, 3);
    tick();
    tick();
    rstb = 1'b0;
    tick();
    rstb = 1'b1;
    check("midrst_out_valid", 32'(bus.out_valid), 0);
    check("midrst_in_ready", 32'(bus.in_ready), 1);
    check("midrst_busy", 32'(bus.busy), 0);
    check("midrst_out_data", {16'h0, bus.out_data}, 0);
    check("midrst_tags", {bus.out_filt, bus.out_row, bus.out_col}, 0);
    q.delete();
    repeat (3) begin
      tick();
      check("midrst_no_output", 32'(bus.out_valid), 0);
    end
    push_all(16'd2304);
    base = n_out;
    load_frame(0, 16'd256, 1'b1);
    wait_done(base);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/conv2d_engine.md
# conv2d_engine

Parametrised, handshake-driven 2-D convolution layer for the CNN datapath. It replaces the fixed 28×28 / 3×3 / 16-filter / stride-2 array-port convolution with a general engine. It loads one frame over a valid/ready pixel stream and takes filter weights through a write port. It then emits every output feature value as a tagged stream with backpressure, using signed fixed-point arithmetic with saturation.

## Interface
Parameters:
- `IMG_SIZE`, 28: input frame is IMG_SIZE×IMG_SIZE pixels.
- `K`, 3: filter kernel is K×K.
- `NUM_FILT`, 16: number of filters (output channels).
- `STRIDE`, 2: window step in both dimensions.
- `DATA_W`, 16: signed pixel, weight and output width.
- `FRAC_W`, 8: fractional bits of the fixed-point format.
- Derived `OUT_SIZE` = (IMG_SIZE−K)/STRIDE+1, 13 by default.
- Derived `ACC_W` = 2·DATA_W + clog2(K·K).

Ports:
- `clk`, in, 1: the single clock; all logic is on its rising edge.
- `rstb`, in, 1: synchronous, active-low reset.
- `in_valid`, in, 1: input pixel is valid.
- `in_ready`, out, 1: the engine accepts a pixel.
- `in_data`, in, DATA_W: signed input pixel, raster order.
- `w_we`, in, 1: weight write enable.
- `w_addr`, in, clog2(NUM_FILT·K·K): weight address, = f·K·K + ky·K + kx.
- `w_data`, in, DATA_W: signed weight.
- `out_valid`, out, 1: an output value is presented.
- `out_ready`, in, 1: the consumer accepts the output.
- `out_data`, out, DATA_W: saturated convolution result.
- `out_filt`, out, clog2(NUM_FILT): filter index tag.
- `out_row`, `out_col`, out, clog2(OUT_SIZE): output position tags.
- `busy`, out, 1: high in the COMPUTE and EMIT states.
- `frame_done`, out, 1: one-cycle pulse after the last output is accepted.

## Operation
The FSM has four states: IDLE, LOAD, COMPUTE and EMIT.

- **IDLE**
  - `in_ready`=1.
  - The first `in_valid`&`in_ready` stores pixel 0 and moves to LOAD.
- **LOAD**
  - `in_ready`=1.
  - Each handshake writes `frame[pix_cnt]`.
  - When pixel IMG_SIZE²−1 is accepted, the FSM clears the position and filter counters and the accumulator, then moves to COMPUTE.
- **COMPUTE**
  - One MAC per cycle over tap t = 0…K²−1.
  - acc += frame[(row·STRIDE+ky)·IMG_SIZE + col·STRIDE+kx] × weight[filt·K²+t], using a full 2·DATA_W signed product.
  - After tap K²−1 the FSM moves to EMIT.
- **EMIT**
  - `out_valid`=1.
  - `out_data` = sat(acc >>> FRAC_W) to [−2^(DATA_W−1), 2^(DATA_W−1)−1]. The shift is arithmetic.
  - On `out_ready` the FSM advances filt, then col, then row (filter innermost) and clears acc.
  - It returns to COMPUTE, or, after the final (OUT_SIZE−1, OUT_SIZE−1, NUM_FILT−1) handshake, pulses `frame_done` and goes to IDLE.
- **Weights**
  - `w_we` writes are accepted in IDLE and LOAD.
  - Writes in COMPUTE or EMIT are ignored.
  - Weights persist across frames. They are not cleared by reset; contents are undefined until written.
- `in_ready`=0 in COMPUTE and EMIT.

## Timing
- Reset values:
  - state=IDLE.
  - `in_ready`=1, `out_valid`=0, `busy`=0, `frame_done`=0.
  - `out_data`, `out_filt`, `out_row`, `out_col` = 0.
  - All counters and acc = 0.
- Latency:
  - From the last pixel accepted to the first `out_valid`: K²+1 cycles.
  - Minimum cost per output is K²+1 cycles: K² MAC cycles plus 1 EMIT cycle with `out_ready`=1.
  - With defaults and no stall, 2704 outputs × 10 = 27040 cycles.
- Backpressure:
  - `out_valid` stays high and `out_data` and the tags stay stable while `out_ready`=0.
  - No value is dropped or duplicated.
- `frame_done` is asserted in the cycle after the final output handshake. `in_ready` returns to 1 in that same cycle.
- Reset mid-operation (`rstb`=0 on any edge) aborts the frame and returns all outputs to their reset values the next cycle. Partial results are never emitted.
- If `in_valid` is asserted while `in_ready`=0, it is ignored.

## Configuration
- `CONV_RELU_EN` defined:
  - `out_data` = max(0, sat(acc >>> FRAC_W)).
  - Negative results are emitted as 0.
- `CONV_RELU_EN` undefined:
  - Signed saturated results are emitted unchanged.
- Timing is identical in both builds.

## Test plan
The bench uses IMG_SIZE=5, K=3, STRIDE=2, NUM_FILT=2, DATA_W=16, FRAC_W=8, which gives OUT_SIZE=2.

- **Unity frame:** all weights 256 (1.0), all pixels 256 → 8 outputs, each `out_data`=2304, tags in order (r,c,f) = (0,0,0), (0,0,1), (0,1,0)…(1,1,1), then a single `frame_done` pulse.
- **Position tags:** pixel i = i·256, filter 0 with a centre tap of 256 and all other taps 0 → outputs 6, 8, 16, 18 (×256) at (0,0), (0,1), (1,0), (1,1).
- **Saturation:** all pixels and weights 0x7FFF → `out_data`=0x7FFF; with weights 0x8001 → 0x8000.
- **ReLU:** weights −256 and pixels 256 → `out_data`=−2304 (0xF700) without `CONV_RELU_EN`, 0 with it.
- **Backpressure:**
  - Hold `out_ready`=0 for 7 cycles at every output → values and tags are held stable and all 8 outputs appear exactly once.
  - `w_we` writes made during COMPUTE leave the results unchanged.
- **Mid-operation reset:** `rstb`=0 for 1 cycle during COMPUTE of output 3 → the next cycle shows `out_valid`=0 and `in_ready`=1; a fresh frame then reproduces the unity result.
